// File: rtl/ram_2p_arb.sv
// ram_2p_arb: shares a synchronous dual-port SRAM among NumReq requesters.
//   Port A is round-robin arbitrated between the requesters. Port B belongs to
//   an internal clear engine that zero-fills the whole array after reset
//   (when ClearOnReset=1) or on a clear_i pulse. Requesters are blocked while
//   the clear runs, so port A and port B never touch the same word at once.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_i/we_i                per-requester request / write enable
//   addr_i/wdata_i/wmask_i    packed per-requester payload (requester k at slot k)
//   gnt_o                     one-hot combinational grant
//   rvalid_o                  one-hot response valid, one cycle after the grant
//   rdata_o                   read data, non-zero only with the rvalid of a read
//   clear_i                   start a clear (ignored while one is running)
//   busy_o, clear_done_o      clear active / one-cycle pulse when it finishes
//   ram_a_*                   RAM port A (requesters), ram_a_rdata_i 1-cycle latency
//   ram_b_*                   RAM port B (clear engine, write only)
module ram_2p_arb #(
  parameter int NumReq       = 3,
  parameter int Width        = 32,
  parameter int Depth        = 128,
  parameter bit ClearOnReset = 1'b1,
  localparam int Aw          = $clog2(Depth)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq-1:0]       we_i,
  input  logic [NumReq*Aw-1:0]    addr_i,
  input  logic [NumReq*Width-1:0] wdata_i,
  input  logic [NumReq*Width-1:0] wmask_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       rvalid_o,
  output logic [Width-1:0]        rdata_o,
  input  logic                    clear_i,
  output logic                    busy_o,
  output logic                    clear_done_o,
  output logic                    ram_a_req_o,
  output logic                    ram_a_write_o,
  output logic [Aw-1:0]           ram_a_addr_o,
  output logic [Width-1:0]        ram_a_wdata_o,
  output logic [Width-1:0]        ram_a_wmask_o,
  input  logic [Width-1:0]        ram_a_rdata_i,
  output logic                    ram_b_req_o,
  output logic                    ram_b_write_o,
  output logic [Aw-1:0]           ram_b_addr_o,
  output logic [Width-1:0]        ram_b_wdata_o,
  output logic [Width-1:0]        ram_b_wmask_o
);

  localparam int          PtrW     = $clog2(NumReq);
  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
  localparam logic [PtrW-1:0] LastReq = PtrW'(NumReq - 1);

  typedef enum logic {
    StReady = 1'b0,
    StClear = 1'b1
  } state_e;

  state_e              state_q;
  logic [Aw-1:0]       cnt_q;
  logic                done_q;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NumReq-1:0]   rvalid_q;
  logic                rd_q;

  logic [NumReq-1:0]   gnt;
  logic                gnt_any;
  logic [PtrW-1:0]     gidx;
  logic                sel_we;
  logic [Aw-1:0]       sel_addr;
  logic [Width-1:0]    sel_wdata;
  logic [Width-1:0]    sel_wmask;

  // Round-robin pick: first pass looks at indices >= ptr, the second pass
  // wraps around to the low indices only if the first found nothing.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gidx    = '0;
    if (state_q == StReady) begin
      for (int i = 0; i < NumReq; i++) begin
        if (!gnt_any && req_i[i] && (PtrW'(i) >= ptr_q)) begin
          gnt_any = 1'b1;
          gidx    = PtrW'(i);
          gnt[i]  = 1'b1;
        end
      end
      for (int i = 0; i < NumReq; i++) begin
        if (!gnt_any && req_i[i]) begin
          gnt_any = 1'b1;
          gidx    = PtrW'(i);
          gnt[i]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gidx == LastReq) ? '0 : gidx + 1'b1;
    end
  end

  // Port A payload mux; everything stays zero when nobody is granted.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        sel_we    = we_i[i];
        sel_addr  = addr_i[i*Aw +: Aw];
        sel_wdata = wdata_i[i*Width +: Width];
        sel_wmask = wmask_i[i*Width +: Width];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ClearOnReset ? StClear : StReady;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ptr_q    <= '0;
      rvalid_q <= '0;
      rd_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= gnt;
      rd_q     <= gnt_any & ~sel_we;
      done_q   <= 1'b0;
      case (state_q)
        StReady: begin
          if (clear_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          // The last word is written this cycle; the done pulse lands on the
          // first READY cycle.
          if (cnt_q == LastAddr) begin
            state_q <= StReady;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StReady;
      endcase
    end
  end

  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rd_q ? ram_a_rdata_i : '0;
  assign busy_o       = (state_q == StClear);
  assign clear_done_o = done_q;

  assign ram_a_req_o   = gnt_any;
  assign ram_a_write_o = sel_we;
  assign ram_a_addr_o  = sel_addr;
  assign ram_a_wdata_o = sel_wdata;
  assign ram_a_wmask_o = sel_wmask;

  assign ram_b_req_o   = busy_o;
  assign ram_b_write_o = busy_o;
  assign ram_b_addr_o  = busy_o ? cnt_q : '0;
  assign ram_b_wdata_o = '0;
  assign ram_b_wmask_o = busy_o ? '1 : '0;

endmodule

// File: tb/tb_ram_2p_arb.sv
// Bench for ram_2p_arb: a full-size instance (Depth=128) driven by directed and
// random requester traffic against a behavioural model, plus a Depth=100
// instance whose clear engine is watched for address range and length.
module tb_ram_2p_arb;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;
  localparam int D2 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*W-1:0]  wdata, wmask;
  logic            clear;

  logic [N-1:0]    gnt, rvalid;
  logic [W-1:0]    rdata;
  logic            busy, done;
  logic            a_req, a_write, b_req, b_write;
  logic [AW-1:0]   a_addr, b_addr;
  logic [W-1:0]    a_wdata, a_wmask, a_rdata, b_wdata, b_wmask;

  logic [N-1:0]    gnt2, rvalid2;
  logic [W-1:0]    rdata2;
  logic            busy2, done2;
  logic            a_req2, a_write2, b_req2, b_write2;
  logic [AW-1:0]   a_addr2, b_addr2;
  logic [W-1:0]    a_wdata2, a_wmask2, b_wdata2, b_wmask2;
  logic [W-1:0]    zero_w = '0;
  logic [N-1:0]    zero_n = '0;

  ram_2p_arb #(.NumReq(N), .Width(W), .Depth(D), .ClearOnReset(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .clear_i(clear), .busy_o(busy), .clear_done_o(done),
    .ram_a_req_o(a_req), .ram_a_write_o(a_write), .ram_a_addr_o(a_addr),
    .ram_a_wdata_o(a_wdata), .ram_a_wmask_o(a_wmask), .ram_a_rdata_i(a_rdata),
    .ram_b_req_o(b_req), .ram_b_write_o(b_write), .ram_b_addr_o(b_addr),
    .ram_b_wdata_o(b_wdata), .ram_b_wmask_o(b_wmask)
  );

  ram_2p_arb #(.NumReq(N), .Width(W), .Depth(D2), .ClearOnReset(1'b1)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(zero_n), .we_i(zero_n), .addr_i('0),
    .wdata_i('0), .wmask_i('0), .gnt_o(gnt2), .rvalid_o(rvalid2),
    .rdata_o(rdata2), .clear_i(clear), .busy_o(busy2), .clear_done_o(done2),
    .ram_a_req_o(a_req2), .ram_a_write_o(a_write2), .ram_a_addr_o(a_addr2),
    .ram_a_wdata_o(a_wdata2), .ram_a_wmask_o(a_wmask2), .ram_a_rdata_i(zero_w),
    .ram_b_req_o(b_req2), .ram_b_write_o(b_write2), .ram_b_addr_o(b_addr2),
    .ram_b_wdata_o(b_wdata2), .ram_b_wmask_o(b_wmask2)
  );

  // RAM macro stand-in: synchronous, masked writes, 1-cycle read on port A.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (a_req) begin
      if (a_write) mem[a_addr] <= (mem[a_addr] & ~a_wmask) | (a_wdata & a_wmask);
      else         a_rdata <= mem[a_addr];
    end
    if (b_req && b_write) mem[b_addr] <= (mem[b_addr] & ~b_wmask) | (b_wdata & b_wmask);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side pending transactions (held until granted).
  bit          p_req [N];
  bit          p_we  [N];
  int          p_addr[N];
  logic [W-1:0] p_wd [N];
  logic [W-1:0] p_m  [N];

  // Reference model state.
  int           m_left;   // clear cycles still to run
  bit           m_done;
  int           m_ptr;
  logic [N-1:0] m_rv;
  logic [W-1:0] m_rdata;
  logic [W-1:0] sh [D];
  int           c2;       // port B writes seen on the Depth=100 instance

  task automatic zero_sh();
    for (int i = 0; i < D; i++) sh[i] = '0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k] = p_req[k];
      we[k]  = p_we[k];
      addr[k*AW +: AW] = AW'(p_addr[k]);
      wdata[k*W +: W]  = p_wd[k];
      wmask[k*W +: W]  = p_m[k];
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    int g;
    logic [N-1:0] eg;
    drive();
    #2;
    g = -1;
    if (m_left == 0) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (g < 0 && p_req[j]) g = j;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", gnt, eg);
    check("busy", busy, m_left > 0);
    check("clear_done", done, m_done);
    check("rvalid", rvalid, m_rv);
    check("rdata", rdata, m_rdata);
    check("a_req", a_req, g >= 0);
    if (g >= 0) begin
      check("a_write", a_write, p_we[g]);
      check("a_addr", a_addr, p_addr[g]);
      check("a_wdata", a_wdata, p_wd[g]);
      check("a_wmask", a_wmask, p_m[g]);
    end else begin
      check("a_idle", {a_write, a_addr, a_wdata, a_wmask}, 0);
    end
    if (m_left > 0) begin
      check("b_addr", b_addr, D - m_left);
      check("b_wr", {b_req, b_write, b_wdata, b_wmask}, {2'b11, 32'h0, 32'hFFFF_FFFF});
    end else begin
      check("b_idle", {b_req, b_write, b_addr, b_wmask}, 0);
    end
    if (busy2) begin
      check("b2_addr", b_addr2, c2);
      c2++;
    end
    if (done2) begin
      check("b2_len", c2, D2);
      c2 = 0;
    end

    m_rv    = eg;
    m_rdata = '0;
    if (g >= 0) begin
      if (p_we[g]) sh[p_addr[g]] = (sh[p_addr[g]] & ~p_m[g]) | (p_wd[g] & p_m[g]);
      else         m_rdata = sh[p_addr[g]];
      m_ptr = (g + 1) % N;
      p_req[g] = 1'b0;
    end
    if (rst) begin
      m_left = D; m_ptr = 0; m_rv = '0; m_rdata = '0; m_done = 1'b0; c2 = 0;
      zero_sh();
    end else begin
      m_done = (m_left == 1);
      if (m_left > 0) m_left--;
      else if (clear) begin
        m_left = D;
        zero_sh();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gen();
    for (int k = 0; k < N; k++) begin
      if (!p_req[k] && $urandom_range(0, 2) == 0) begin
        p_req[k]  = 1'b1;
        p_we[k]   = 1'($urandom_range(0, 1));
        p_addr[k] = $urandom_range(8, 23);
        p_wd[k]   = $urandom;
        p_m[k]    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((p_req[0] || p_req[1] || p_req[2]) && t < 400) begin
      step();
      t++;
    end
    check("drain_timeout", t >= 400, 0);
  endtask

  task automatic access(input int k, input bit w, input int a, input logic [W-1:0] wd,
                        input logic [W-1:0] m, output logic [W-1:0] rd);
    int t;
    t = 0;
    p_req[k] = 1'b1; p_we[k] = w; p_addr[k] = a; p_wd[k] = wd; p_m[k] = m;
    while (p_req[k] && t < 400) begin
      step();
      t++;
    end
    check("acc_timeout", p_req[k], 0);
    p_req[k] = 1'b0;
    check("acc_rvalid", rvalid[k], 1);
    rd = rdata;
  endtask

  logic [W-1:0] rd;

  initial begin
    for (int k = 0; k < N; k++) begin
      p_req[k] = 0; p_we[k] = 0; p_addr[k] = 0; p_wd[k] = '0; p_m[k] = '0;
    end
    clear = 1'b0;
    rst   = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    m_left = D; m_done = 1'b0; m_ptr = 0; m_rv = '0; m_rdata = '0; c2 = 0;
    zero_sh();
    rst = 1'b0;

    // Clear after reset, then idle.
    repeat (D + 3) step();

    // All three reading continuously: rotation 0,1,2,0,...
    for (int c = 0; c < 9; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!p_req[k]) begin
          p_req[k] = 1'b1; p_we[k] = 1'b0; p_addr[k] = k + 1; p_wd[k] = '0; p_m[k] = '0;
        end
      end
      step();
    end
    drain();

    // Masked write then read-back by requester 1.
    access(1, 1'b1, 5, 32'hDEAD_BEEF, 32'hFFFF_0000, rd);
    access(1, 1'b0, 5, 32'h0, 32'h0, rd);
    check("masked_rd", rd, 32'hDEAD_0000);

    // Clear requested in the same cycle as a read grant.
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 5; p_wd[0] = '0; p_m[0] = '0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_same_rv", rvalid[0], 1);
    check("clr_same_rd", rdata, 32'hDEAD_0000);
    repeat (D) begin
      gen();
      step();
    end
    drain();
    access(2, 1'b0, 5, 32'h0, 32'h0, rd);
    check("post_clear_rd", rd, 0);

    // Reset in the middle of a clear.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (60) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (D + 3) step();

    // Random traffic with occasional clears.
    repeat (1500) begin
      gen();
      clear = ($urandom_range(0, 299) == 0);
      step();
      clear = 1'b0;
    end
    repeat (D + 2) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_2p_arb.md
Name: ram_2p_arb

Overview:
- Shares a synchronous dual-port SRAM (1-cycle read latency, bit write mask) among NumReq on-chip requesters (core data, DMA, debug).
- Port A: round-robin arbitration between requesters.
- Port B: owned by an internal clear engine that zero-fills the array after reset or on command.
- Sits between the requesters and the RAM macro inside the memory subsystem.

Parameters:
- NumReq, 3, number of requesters (≥2)
- Width, 32, data width in bits
- Depth, 128, RAM words (need not be a power of two)
- ClearOnReset, 1, when 1, run the clear sequence automatically after reset
- Aw, $clog2(Depth), derived address width (localparam)

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  NumReq  per-requester access request
- we_i  in  NumReq  per-requester write enable
- addr_i  in  NumReq*Aw  packed addresses, requester k at [k*Aw +: Aw]
- wdata_i  in  NumReq*Width  packed write data
- wmask_i  in  NumReq*Width  packed bit write masks
- gnt_o  out  NumReq  one-hot grant (combinational)
- rvalid_o  out  NumReq  one-hot response valid, one cycle after grant
- rdata_o  out  Width  shared read data, valid with rvalid_o of a read
- clear_i  in  1  start clear (single-cycle pulse)
- busy_o  out  1  clear engine active
- clear_done_o  out  1  one-cycle pulse after last clear write
- ram_a_req_o / ram_a_write_o  out  1 / 1  RAM port A request / write
- ram_a_addr_o  out  Aw  RAM port A address
- ram_a_wdata_o / ram_a_wmask_o  out  Width / Width  RAM port A data / mask
- ram_a_rdata_i  in  Width  RAM port A read data
- ram_b_req_o / ram_b_write_o  out  1 / 1  RAM port B request / write
- ram_b_addr_o  out  Aw  RAM port B address
- ram_b_wdata_o / ram_b_wmask_o  out  Width / Width  RAM port B data / mask

Behaviour:
- Reset (rst_i=1 at clk edge):
  - rr pointer=0; rvalid_o=0; clear counter=0; clear_done_o=0.
  - FSM → CLEAR if ClearOnReset=1, else READY.
  - Reset mid-clear restarts the sequence from address 0.
- FSM, state READY:
  - busy_o=0; ram_b_req_o=0; port B outputs are 0.
  - clear_i=1 → CLEAR with counter=0.
  - A request granted in the same cycle as clear_i completes normally.
- FSM, state CLEAR:
  - busy_o=1.
  - Each cycle drive ram_b_req_o=1, ram_b_write_o=1, ram_b_addr_o=counter, ram_b_wdata_o=0, ram_b_wmask_o=all ones.
  - Increment counter each cycle.
  - When counter==Depth-1 is written: → READY next cycle and pulse clear_done_o for exactly one cycle (the first READY cycle).
  - clear_i is ignored while in CLEAR.
  - Clear takes exactly Depth cycles.
- Arbitration, all gnt_o=0 while busy_o=1:
  - Otherwise grant the first asserted req_i scanning from index ptr upward, with wrap modulo NumReq.
  - gnt_o is combinational from req_i and is held for one cycle only.
  - Requester keeps req_i and its payload stable until granted.
  - On a grant to index g: ptr ← (g+1) mod NumReq. With no grant, ptr holds.
- Port A, same cycle as grant:
  - ram_a_req_o=1; ram_a_write_o=we_i[g]; addr, wdata and wmask are muxed from requester g.
  - No grant: ram_a_req_o=0, other port A outputs 0.
- Response:
  - A registered one-hot copy of gnt_o drives rvalid_o one cycle later, for reads and writes alike.
  - rdata_o = ram_a_rdata_i when the rvalid is for a read; otherwise rdata_o = 0.
- Throughput: one grant per cycle; back-to-back grants to different or the same requester are allowed.
- Port B never writes while READY, so same-address port A/B collisions occur only during CLEAR, where port A is blocked.

Test Plan:
- ClearOnReset=1, Depth=128: release rst_i → busy_o=1 for 128 cycles, port B writes addresses 0..127 with data 0, clear_done_o pulses on cycle 129, busy_o=0 from then on.
- After clear: req_i=3'b111 held, all reads → grants in order 0,1,2,0,… (ptr=0 start), one per cycle. Each rvalid_o[k] follows its gnt_o[k] by exactly 1 cycle.
- Requester 1 writes 0xDEADBEEF to addr 5 with mask 0xFFFF0000, then reads addr 5 → rvalid_o[1]=1 for both accesses; read returns rdata_o=0xDEAD0000.
- Assert clear_i while req_i[0]=1 → that cycle's request is granted and completes. From the next cycle gnt_o=0 for 128 cycles, then grants resume; a read of addr 5 returns 0.
- Assert rst_i at clear counter=60 → counter restarts at 0 and a full 128-cycle clear follows; clear_done_o does not pulse early.
- Depth=100: clear writes addresses 0..99 only, never 100..127, then returns to READY.
